// File: rtl/iw_move_sequencer_if.sv
// iw_move_sequencer_if: instruction handshake and datapath control bundle for the move-wide sequencer
interface iw_move_sequencer_if #(parameter int DATA_WIDTH = 64);
  logic                  start;
  logic [31:0]           I;
  logic                  ready;
  logic                  busy;
  logic                  alu_en;
  logic                  alu_b_sel;
  logic [4:0]            alu_fs;
  logic [DATA_WIDTH-1:0] const_out;
  logic [4:0]            reg_sel_a;
  logic [4:0]            reg_wa;
  logic                  reg_write;
  logic                  done;
  logic                  illegal;
  modport master (output start, I, input ready, busy, alu_en, alu_b_sel, alu_fs, const_out, reg_sel_a, reg_wa, reg_write, done, illegal);
  modport slave (input start, I, output ready, busy, alu_en, alu_b_sel, alu_fs, const_out, reg_sel_a, reg_wa, reg_write, done, illegal);
endinterface

// File: rtl/iw_move_sequencer.sv
// iw_move_sequencer: decodes MOVZ/MOVN/MOVK and sequences ALU, register file and constant path
module iw_move_sequencer #(
  parameter int         DATA_WIDTH = 64,
  parameter int         HW_SLOTS   = DATA_WIDTH / 16,
  parameter logic [4:0] FS_AND     = 5'b00000,
  parameter logic [4:0] FS_OR      = 5'b00100,
  parameter logic [4:0] FS_PASSB   = 5'b01100
) (
  input logic clock,
  input logic reset,
  iw_move_sequencer_if.slave bus
);
  localparam logic [8:0] OP_MOVZ = 9'h1A5;
  localparam logic [8:0] OP_MOVN = 9'h125;
  localparam logic [8:0] OP_MOVK = 9'h1E5;
  typedef enum logic [2:0] {IDLE, EXEC_Z, EXEC_N, MASK_K, MERGE_K, ERR} state_t;
  state_t state_q, state_d, dec_st;
  logic [22:0] instr_q, instr_d;
  logic [8:0] in_op;
  logic [1:0] in_hw;
  logic [4:0] rd;
  logic [5:0] shamt;
  logic [DATA_WIDTH-1:0] shifted, hw_mask;
  logic exec;
  assign in_op = bus.I[31:23];
  assign in_hw = bus.I[22:21];
  assign dec_st = int'(in_hw) >= HW_SLOTS ? ERR :
                  in_op == OP_MOVZ ? EXEC_Z :
                  in_op == OP_MOVN ? EXEC_N :
                  in_op == OP_MOVK ? MASK_K : ERR;
  always_comb begin
    state_d = state_q == IDLE ? (bus.start ? dec_st : IDLE) : state_q == MASK_K ? MERGE_K : IDLE;
    instr_d = (state_q == IDLE && bus.start) ? bus.I[22:0] : instr_q;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  // Only the latched word feeds the outputs, so I/start never reach them combinationally
  assign rd      = instr_q[4:0];
  assign shamt   = {instr_q[22:21], 4'b0};
  assign shifted = {{(DATA_WIDTH-16){1'b0}}, instr_q[20:5]} << shamt;
  assign hw_mask = ~({{(DATA_WIDTH-16){1'b0}}, 16'hFFFF} << shamt);
  assign exec    = state_q inside {EXEC_Z, EXEC_N, MASK_K, MERGE_K};
  assign bus.ready     = state_q == IDLE;
  assign bus.busy      = state_q != IDLE;
  assign bus.alu_en    = exec;
  assign bus.alu_b_sel = exec;
  assign bus.alu_fs    = state_q == MASK_K ? FS_AND : state_q == MERGE_K ? FS_OR :
                         (state_q == EXEC_Z || state_q == EXEC_N) ? FS_PASSB : 5'd0;
  assign bus.const_out = state_q == EXEC_Z ? shifted : state_q == EXEC_N ? ~shifted :
                         state_q == MASK_K ? hw_mask : state_q == MERGE_K ? shifted : '0;
  assign bus.reg_sel_a = (state_q == MASK_K || state_q == MERGE_K) ? rd : 5'd0;
  assign bus.reg_wa    = exec ? rd : 5'd0;
  assign bus.reg_write = exec && rd != 5'd31;
  assign bus.done      = state_q inside {EXEC_Z, EXEC_N, MERGE_K};
  assign bus.illegal   = state_q == ERR;
endmodule

// File: tb/tb_iw_move_sequencer.sv
// tb_iw_move_sequencer: directed vectors against a per-cycle expected-output queue plus literal pins
module tb_iw_move_sequencer;
  typedef struct packed {
    logic        ready, busy, alu_en, alu_b_sel;
    logic [4:0]  alu_fs;
    logic [63:0] const_out;
    logic [4:0]  reg_sel_a, reg_wa;
    logic        reg_write, done, illegal;
  } rec_t;
  logic clock = 0;
  logic reset = 0;
  int vectors = 0;
  int miscompares = 0;
  rec_t pend[$];
  rec_t idle_rec, exp_r, act_r;
  logic [63:0] rf [32];
  logic [63:0] alu_a, alu_b;
  iw_move_sequencer_if #(.DATA_WIDTH(64)) b();
  iw_move_sequencer_if #(.DATA_WIDTH(32)) b32();
  iw_move_sequencer #(.DATA_WIDTH(64)) dut (.clock(clock), .reset(reset), .bus(b));
  iw_move_sequencer #(.DATA_WIDTH(32)) dut32 (.clock(clock), .reset(reset), .bus(b32));
  always #5 clock = ~clock;
  function automatic void push_seq(input logic [31:0] w);
    logic [8:0] op = w[31:23];
    int hw = int'(w[22:21]);
    logic [63:0] sh = 64'(w[20:5]) << (16 * hw);
    rec_t r = '0;
    r.busy = 1;
    if (op != 9'h1A5 && op != 9'h125 && op != 9'h1E5) begin
      r.illegal = 1;
      pend.push_back(r);
      return;
    end
    r.alu_en = 1; r.alu_b_sel = 1; r.reg_wa = w[4:0]; r.reg_write = w[4:0] != 5'd31;
    if (op == 9'h1E5) begin
      r.alu_fs = 5'b00000; r.reg_sel_a = w[4:0]; r.const_out = ~(64'hFFFF << (16 * hw));
      pend.push_back(r);
      r.alu_fs = 5'b00100; r.const_out = sh; r.done = 1;
      pend.push_back(r);
    end else begin
      r.alu_fs = 5'b01100; r.const_out = op == 9'h125 ? ~sh : sh; r.done = 1;
      pend.push_back(r);
    end
  endfunction
  always @(posedge clock or negedge reset)
    if (!reset) pend.delete();
    else if (pend.size() != 0) void'(pend.pop_front());
    else if (b.start) push_seq(b.I);
  always @(negedge clock) begin
    idle_rec = '0;
    idle_rec.ready = 1;
    exp_r = pend.size() != 0 ? pend[0] : idle_rec;
    act_r = '{ready: b.ready, busy: b.busy, alu_en: b.alu_en, alu_b_sel: b.alu_b_sel, alu_fs: b.alu_fs,
               const_out: b.const_out, reg_sel_a: b.reg_sel_a, reg_wa: b.reg_wa, reg_write: b.reg_write,
               done: b.done, illegal: b.illegal};
    vectors++;
    if (act_r !== exp_r) begin
      miscompares++;
      $display("FAIL cycle_cmp t=%0t got=%h want=%h", $time, act_r, exp_r);
    end
  end
  // Reference register file and ALU driven by the DUT's control outputs
  always_comb begin
    alu_a = rf[b.reg_sel_a];
    alu_b = b.alu_b_sel ? b.const_out : 64'd0;
  end
  always @(posedge clock)
    if (reset && b.alu_en && b.reg_write)
      rf[b.reg_wa] <= b.alu_fs == 5'b00000 ? (alu_a & alu_b) : b.alu_fs == 5'b00100 ? (alu_a | alu_b) : alu_b;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask
  task automatic tick;
    @(posedge clock);
    #2;
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 64'hFFFF_FFFF_FFFF_FFFF;
    b.start = 0; b.I = '0; b32.start = 0; b32.I = '0;
    #1;
    chk("rst_ready", 64'(b.ready), 64'd1);
    chk("rst_busy", 64'(b.busy), 64'd0);
    chk("rst_const", b.const_out, 64'd0);
    chk("rst_wa", 64'(b.reg_wa), 64'd0);
    tick; tick;
    reset = 1;
    tick;
    b.start = 1; b.I = 32'hD2B7DDE3;
    tick;
    b.start = 0;
    chk("movz_const", b.const_out, 64'h00000000BEEF0000);
    chk("movz_fs", 64'(b.alu_fs), 64'h0C);
    chk("movz_wa", 64'(b.reg_wa), 64'd3);
    chk("movz_wr", 64'(b.reg_write), 64'd1);
    chk("movz_done", 64'(b.done), 64'd1);
    tick;
    chk("movz_ready", 64'(b.ready), 64'd1);
    b.start = 1; b.I = 32'hF2E24685;
    tick;
    b.start = 0;
    chk("movk_mask_const", b.const_out, 64'h0000FFFFFFFFFFFF);
    chk("movk_mask_fs", 64'(b.alu_fs), 64'h00);
    tick;
    chk("movk_merge_const", b.const_out, 64'h1234000000000000);
    chk("movk_merge_fs", 64'(b.alu_fs), 64'h04);
    chk("movk_merge_done", 64'(b.done), 64'd1);
    tick;
    chk("movk_x5", rf[5], 64'h1234FFFFFFFFFFFF);
    b.start = 1; b.I = 32'h92800001;
    tick;
    b.start = 0;
    chk("movn_const", b.const_out, 64'hFFFFFFFFFFFFFFFF);
    chk("movn_wr", 64'(b.reg_write), 64'd1);
    tick;
    b.start = 1; b.I = 32'h9280001F;
    tick;
    b.start = 0;
    chk("xzr_const", b.const_out, 64'hFFFFFFFFFFFFFFFF);
    chk("xzr_wr", 64'(b.reg_write), 64'd0);
    chk("xzr_done", 64'(b.done), 64'd1);
    tick;
    b.start = 1; b.I = 32'hF2E24685;
    tick;
    b.I = 32'hD2B7DDE3;
    chk("held_mask_busy", 64'(b.busy), 64'd1);
    tick;
    chk("held_merge_const", b.const_out, 64'h1234000000000000);
    tick;
    chk("held_ready", 64'(b.ready), 64'd1);
    tick;
    b.start = 0;
    chk("held_movz_done", 64'(b.done), 64'd1);
    chk("held_movz_const", b.const_out, 64'h00000000BEEF0000);
    tick;
    b32.start = 1; b32.I = {9'h1A5, 2'd2, 16'h00AB, 5'd2};
    tick;
    b32.start = 0;
    chk("w32_hw2_illegal", 64'(b32.illegal), 64'd1);
    chk("w32_hw2_wr", 64'(b32.reg_write), 64'd0);
    chk("w32_hw2_done", 64'(b32.done), 64'd0);
    tick;
    chk("w32_hw2_pulse", 64'(b32.illegal), 64'd0);
    chk("w32_hw2_ready", 64'(b32.ready), 64'd1);
    b32.start = 1; b32.I = 32'h8B020020;
    tick;
    b32.start = 0;
    chk("w32_unk_illegal", 64'(b32.illegal), 64'd1);
    chk("w32_unk_wr", 64'(b32.reg_write), 64'd0);
    tick;
    chk("w32_unk_pulse", 64'(b32.illegal), 64'd0);
    b32.start = 1; b32.I = 32'hD2B7DDE3;
    tick;
    b32.start = 0;
    chk("w32_movz_const", 64'(b32.const_out), 64'h00000000BEEF0000);
    chk("w32_movz_wr", 64'(b32.reg_write), 64'd1);
    b.start = 1; b.I = 32'hF2E24685;
    tick;
    b.start = 0;
    chk("rst_mid_mask", 64'(b.alu_fs), 64'h00);
    reset = 0;
    #1;
    chk("rst_mid_ready", 64'(b.ready), 64'd1);
    chk("rst_mid_busy", 64'(b.busy), 64'd0);
    chk("rst_mid_wr", 64'(b.reg_write), 64'd0);
    chk("rst_mid_const", b.const_out, 64'd0);
    tick;
    reset = 1;
    tick;
    chk("post_rst_done", 64'(b.done), 64'd0);
    chk("post_rst_wr", 64'(b.reg_write), 64'd0);
    tick;
    chk("post_rst_ready", 64'(b.ready), 64'd1);
    tick;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
